filter_arbiter: RTL and testbench
=================================

Name: filter_arbiter

Overview:
- Shares one valid-strobed filter datapath between N_REQ sample sources.
- Accepts samples over per-requester valid/ready handshakes and picks a winner round-robin.
- Drives the filter's strobe and sample inputs, and tags every issued sample.
- Routes each filter result back out with its requester ID. A flush request drains in-flight results by injecting bubble strobes.

Parameters:
N_REQ, 2, number of requesters (>=2)
X_W, 4, sample width
Y_W, 6, filter result width
LAT, 2, strobes between issuing a sample and its result on y (>=1)
ID_W, $clog2(N_REQ), requester ID width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester sample valid
req_data  in  N_REQ*X_W  per-requester sample, requester i at bits [i*X_W +: X_W]
req_ready  out  N_REQ  per-requester accept
flush  in  1  single-cycle drain request
x_is_valid  out  1  strobe to filter (registered)
x  out  X_W  sample to filter (registered)
y  in  Y_W  filter result
out_valid  out  1  result pulse (registered)
out_id  out  ID_W  requester that owns out_data
out_data  out  Y_W  captured filter result
busy  out  1  high while any real tag is in flight or state is FLUSH

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset clears the following:
  - x_is_valid=0, x=0, out_valid=0, out_id=0, out_data=0.
  - All tags invalid; RR pointer=0; state RUN.
  - Reset mid-flight discards every in-flight result; no out_valid for them.
- States: RUN, FLUSH.
- RUN arbitration:
  - Among asserted req_valid, grant the first index at or after ptr, wrapping.
  - req_ready[i] is combinational: grant[i] && state==RUN. At most one ready is high.
  - Handshake on edge H (valid&&ready): x<=data, x_is_valid<=1 for the cycle after H. Otherwise x_is_valid<=0 and x holds.
  - ptr<=winner+1 mod N_REQ on handshake; ptr unchanged when idle.
  - Back-to-back handshakes are allowed, one per cycle.
- Tag pipeline: LAT entries {real, id}.
  - On each edge where x_is_valid is high (strobe edge), shift in the tag of the sample being strobed at position 0.
- Result capture:
  - In the cycle after a strobe edge, y belongs to the tag now at position LAT-1.
  - At the next edge: out_data<=y, out_id<=tag.id, out_valid<=tag.real.
  - out_valid is a one-cycle pulse. No backpressure on the output.
- Latency: handshake edge H -> strobe edge H+1 -> result capture edge H+1+LAT (assuming a strobe every cycle). Without further strobes a result stays stuck until flush.
- flush:
  - Sampled in RUN: if any real tag is in flight, go to FLUSH. If the pipeline is empty, flush is a no-op.
  - A handshake in the same cycle as flush is still accepted; that sample is included in the drain.
- FLUSH:
  - All req_ready=0.
  - Each cycle, issue a bubble strobe: x=0, x_is_valid=1, tag real=0.
  - Return to RUN on the edge where the last real tag is captured to the output.
  - flush asserted while in FLUSH is ignored.
- Bubble results never raise out_valid.
- busy is combinational: OR of tag.real bits, the real bit of the sample currently being strobed, and state==FLUSH.
- Width rules: out_data is y unmodified. x is zero-extended/truncated to X_W only via req_data slicing; no arithmetic is done here.

Decomposition:
- Shared package filt_pkg holds:
  - The tag struct {real, id}.
  - State enum {RUN, FLUSH}.
  - Default widths X_W=4, Y_W=6.
- One natural sub-module: rr_arbiter (N_REQ request vector + ptr -> one-hot grant, combinational). The block instantiates it once.

Test Plan:
- Reset with rst=1 mid-stream while tags are in flight -> all outputs 0, ptr=0, no out_valid after rst drops.
- Requesters 0 and 1 both held valid continuously, LAT=2 -> grants alternate 0,1,0,1. out_id sequence 0,1,0,1. First out_valid 3 cycles after first handshake.
- Single requester 1 sends 4'd9 once, then idle -> x=9 strobed once, no out_valid. Flush pulse -> FLUSH, 2 bubble strobes, out_valid once with out_id=1 and out_data=y at capture, then RUN, busy=0.
- flush with empty pipeline -> state stays RUN, no strobe, busy stays 0.
- Handshake and flush in the same cycle -> sample accepted, FLUSH entered next. req_ready low for the whole drain. Pending req_valid accepted the first cycle after returning to RUN.
- LAT=1, N_REQ=3, requesters 0 and 2 valid, ptr=1 -> grant 2 first, then 0. Each result out_valid 2 cycles after its handshake with the correct out_id.

Source files
------------

// File: rtl/filt_pkg.sv
// Shared types for the filter arbiter: requester tag, FSM state, default widths.
package filt_pkg;

    localparam int X_W_DEF  = 4;
    localparam int Y_W_DEF  = 6;
    localparam int TAG_ID_W = 8;

    typedef struct packed {
        logic                is_real;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam tag_t TAG_NONE = '{is_real: 1'b0, id: '0};

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = (int'(ptr) + off) % N_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/filter_arbiter.sv
// Shares one valid-strobed filter between N_REQ requesters; tags each issued
// sample and returns each result with its owner's ID. Flush drains with bubbles.
module filter_arbiter
    import filt_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int X_W   = X_W_DEF,
    parameter int Y_W   = Y_W_DEF,
    parameter int LAT   = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*X_W-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    input  logic               flush,
    output logic               x_is_valid,
    output logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
    output logic               out_valid,
    output logic [ID_W-1:0]    out_id,
    output logic [Y_W-1:0]     out_data,
    output logic               busy
);

    // Handshake: a sample moves on any edge where req_valid[i] && req_ready[i];
    // ready is only offered in RUN, to the single round-robin winner.

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr;
    logic [N_REQ-1:0]   grant;
    logic               hs;
    logic [ID_W-1:0]    win_id;
    logic [X_W-1:0]     win_data;

    tag_t               pipe     [LAT];
    tag_t               pipe_nxt [LAT];
    tag_t               cur_tag, cur_nxt;
    logic               cap_pend;
    logic               pipe_real, pipe_real_nxt;
    logic               xv_nxt;
    logic [X_W-1:0]     x_nxt;
    logic               id_hi_unused;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    assign req_ready = grant & {N_REQ{state == RUN}};
    assign hs        = |(req_valid & req_ready);

    always_comb begin
        win_id   = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_id   = ID_W'(i);
                win_data = req_data[i*X_W +: X_W];
            end
        end
    end

    // Tag pipeline advances only on strobe edges; a captured result that is not
    // pushed out by a new strobe is retired in place so it is never reported twice.
    always_comb begin
        for (int k = 0; k < LAT; k++) pipe_nxt[k] = pipe[k];
        if (x_is_valid) begin
            pipe_nxt[0] = cur_tag;
            for (int k = 1; k < LAT; k++) pipe_nxt[k] = pipe[k-1];
        end else if (cap_pend) begin
            pipe_nxt[LAT-1].is_real = 1'b0;
        end
        pipe_real     = 1'b0;
        pipe_real_nxt = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            pipe_real     = pipe_real | pipe[k].is_real;
            pipe_real_nxt = pipe_real_nxt | pipe_nxt[k].is_real;
        end
    end

    always_comb begin
        state_nxt = state;
        xv_nxt    = 1'b0;
        x_nxt     = x;
        cur_nxt   = cur_tag;
        case (state)
            RUN: begin
                if (hs) begin
                    xv_nxt  = 1'b1;
                    x_nxt   = win_data;
                    cur_nxt = '{is_real: 1'b1, id: TAG_ID_W'(win_id)};
                end
                if (flush && (pipe_real_nxt || hs)) state_nxt = FLUSH;
            end
            FLUSH: begin
                // No bubble on the exit edge: the last real result is captured there.
                if (pipe_real_nxt) begin
                    xv_nxt  = 1'b1;
                    x_nxt   = '0;
                    cur_nxt = TAG_NONE;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            ptr        <= '0;
            x          <= '0;
            x_is_valid <= 1'b0;
            cur_tag    <= TAG_NONE;
            cap_pend   <= 1'b0;
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_data   <= '0;
            for (int k = 0; k < LAT; k++) pipe[k] <= TAG_NONE;
        end else begin
            state      <= state_nxt;
            x          <= x_nxt;
            x_is_valid <= xv_nxt;
            cur_tag    <= cur_nxt;
            cap_pend   <= x_is_valid;
            for (int k = 0; k < LAT; k++) pipe[k] <= pipe_nxt[k];
            if (hs) ptr <= (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + 1'b1;
            out_valid <= cap_pend & pipe[LAT-1].is_real;
            if (cap_pend) begin
                out_data <= y;
                out_id   <= pipe[LAT-1].id[ID_W-1:0];
            end
        end
    end

    assign busy         = pipe_real | (x_is_valid & cur_tag.is_real) | (state == FLUSH);
    assign id_hi_unused = ^pipe[LAT-1].id;

endmodule

// File: tb/tb_filter_arbiter.sv
// Directed bench for filter_arbiter: a 2-requester LAT=2 instance and a
// 3-requester LAT=1 instance, each fed by a small model filter y = {x, 2'b11}.
module tb_filter_arbiter;
    import filt_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [1:0] a_req_valid;
    logic [7:0] a_req_data;
    logic [1:0] a_req_ready;
    logic       a_flush;
    logic       a_xv;
    logic [3:0] a_x;
    logic [5:0] a_y;
    logic       a_ov;
    logic       a_oid;
    logic [5:0] a_od;
    logic       a_busy;
    logic [3:0] a_fx [2];

    logic [2:0]  b_req_valid;
    logic [11:0] b_req_data;
    logic [2:0]  b_req_ready;
    logic        b_flush;
    logic        b_xv;
    logic [3:0]  b_x;
    logic [5:0]  b_y;
    logic        b_ov;
    logic [1:0]  b_oid;
    logic [5:0]  b_od;
    logic        b_busy;
    logic [3:0]  b_fx;

    filter_arbiter #(.N_REQ(2), .X_W(4), .Y_W(6), .LAT(2)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_data(a_req_data),
        .req_ready(a_req_ready), .flush(a_flush), .x_is_valid(a_xv), .x(a_x),
        .y(a_y), .out_valid(a_ov), .out_id(a_oid), .out_data(a_od), .busy(a_busy)
    );

    filter_arbiter #(.N_REQ(3), .X_W(4), .Y_W(6), .LAT(1)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_data(b_req_data),
        .req_ready(b_req_ready), .flush(b_flush), .x_is_valid(b_xv), .x(b_x),
        .y(b_y), .out_valid(b_ov), .out_id(b_oid), .out_data(b_od), .busy(b_busy)
    );

    // Model filters: result of a strobed sample appears LAT strobes later.
    always @(posedge clk) if (a_xv) begin
        a_fx[1] <= a_fx[0];
        a_fx[0] <= a_x;
    end
    assign a_y = {a_fx[1], 2'b11};

    always @(posedge clk) if (b_xv) b_fx <= b_x;
    assign b_y = {b_fx, 2'b11};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_req_valid = '0; a_req_data = '0; a_flush = 1'b0;
        b_req_valid = '0; b_req_data = '0; b_flush = 1'b0;
        tick(); tick(); tick();
        check("rst_xv", a_xv, 0);
        check("rst_x", a_x, 0);
        check("rst_ov", a_ov, 0);
        check("rst_busy", a_busy, 0);
        check("rst_ptr", dut_a.ptr, 0);
        check("rst_state", dut_a.state, RUN);
        rst = 1'b0;

        // Both requesters held valid: grants alternate 0,1,0,1.
        a_req_data  = {4'd5, 4'd3};
        a_req_valid = 2'b11;
        #1;
        check("alt_rdy0", a_req_ready, 2'b01);
        for (int t = 0; t < 8; t++) begin
            tick();
            check("alt_x", a_x, (t % 2 == 0) ? 3 : 5);
            check("alt_xv", a_xv, 1);
            if (t >= 3) begin
                check("alt_ov", a_ov, 1);
                check("alt_id", a_oid, (t - 3) % 2);
                check("alt_od", a_od, ((t - 3) % 2 == 1) ? 23 : 15);
            end else begin
                check("alt_ov_early", a_ov, 0);
            end
        end
        a_req_valid = 2'b00;
        tick();
        check("tail_ov1", a_ov, 1);
        check("tail_id1", a_oid, 1);
        check("tail_xv", a_xv, 0);
        tick();
        check("tail_ov2", a_ov, 1);
        check("tail_id2", a_oid, 0);
        tick();
        check("stuck_ov", a_ov, 0);
        check("stuck_busy", a_busy, 1);

        // Drain the stuck last sample (requester 1, x=5).
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("fl_state", dut_a.state, FLUSH);
        check("fl_xv0", a_xv, 0);
        tick();
        check("fl_bub1_xv", a_xv, 1);
        check("fl_bub1_x", a_x, 0);
        tick();
        check("fl_bub2_xv", a_xv, 1);
        check("fl_bub2_ov", a_ov, 0);
        tick();
        check("fl_cap_ov", a_ov, 1);
        check("fl_cap_id", a_oid, 1);
        check("fl_cap_od", a_od, 23);
        check("fl_exit_state", dut_a.state, RUN);
        check("fl_exit_xv", a_xv, 0);
        check("fl_exit_busy", a_busy, 0);
        tick();
        check("fl_after_ov", a_ov, 0);

        // Single requester 1 sends 9 once, then flush drains it.
        a_req_data  = {4'd9, 4'd0};
        a_req_valid = 2'b10;
        #1;
        check("one_rdy", a_req_ready, 2'b10);
        tick();
        a_req_valid = 2'b00;
        check("one_x", a_x, 9);
        check("one_xv", a_xv, 1);
        check("one_ptr", dut_a.ptr, 0);
        tick();
        check("one_xv_off", a_xv, 0);
        check("one_x_hold", a_x, 9);
        tick();
        check("one_ov_a", a_ov, 0);
        tick();
        check("one_ov_b", a_ov, 0);
        check("one_busy", a_busy, 1);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("one_fl_state", dut_a.state, FLUSH);
        tick();
        check("one_bub1", a_xv, 1);
        check("one_bub1_busy", a_busy, 1);
        tick();
        check("one_bub2", a_xv, 1);
        tick();
        check("one_cap_ov", a_ov, 1);
        check("one_cap_id", a_oid, 1);
        check("one_cap_od", a_od, 39);
        check("one_run", dut_a.state, RUN);
        check("one_busy_end", a_busy, 0);
        check("one_no_bub3", a_xv, 0);

        // Flush with an empty pipeline is a no-op.
        tick();
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("empty_state", dut_a.state, RUN);
        check("empty_xv", a_xv, 0);
        check("empty_busy", a_busy, 0);

        // Handshake and flush in the same cycle.
        a_req_data  = {4'd2, 4'd7};
        a_req_valid = 2'b01;
        a_flush     = 1'b1;
        #1;
        check("hf_rdy", a_req_ready, 2'b01);
        tick();
        a_flush     = 1'b0;
        a_req_valid = 2'b11;
        check("hf_state", dut_a.state, FLUSH);
        check("hf_x", a_x, 7);
        check("hf_xv", a_xv, 1);
        #1;
        check("hf_rdy_d0", a_req_ready, 0);
        tick();
        check("hf_rdy_d1", a_req_ready, 0);
        check("hf_bub1_x", a_x, 0);
        check("hf_bub1_xv", a_xv, 1);
        tick();
        check("hf_rdy_d2", a_req_ready, 0);
        check("hf_state2", dut_a.state, FLUSH);
        tick();
        check("hf_cap_ov", a_ov, 1);
        check("hf_cap_id", a_oid, 0);
        check("hf_cap_od", a_od, 31);
        check("hf_run", dut_a.state, RUN);
        #1;
        check("hf_rdy_run", a_req_ready, 2'b10);
        tick();
        a_req_valid = 2'b00;
        check("hf_pend_x", a_x, 2);
        check("hf_pend_xv", a_xv, 1);

        // Reset while a real tag is in flight.
        tick();
        check("mid_busy", a_busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_xv", a_xv, 0);
        check("mid_x", a_x, 0);
        check("mid_ov", a_ov, 0);
        check("mid_id", a_oid, 0);
        check("mid_od", a_od, 0);
        check("mid_busy0", a_busy, 0);
        check("mid_ptr", dut_a.ptr, 0);
        check("mid_state", dut_a.state, RUN);
        for (int t = 0; t < 4; t++) begin
            tick();
            check("mid_quiet_ov", a_ov, 0);
        end

        // LAT=1, N_REQ=3: move ptr to 1, then requesters 0 and 2 compete.
        b_req_data  = {4'd6, 4'd0, 4'd1};
        b_req_valid = 3'b001;
        tick();
        check("b_h0_x", b_x, 1);
        check("b_ptr1", dut_b.ptr, 1);
        b_req_valid = 3'b101;
        #1;
        check("b_rdy_first", b_req_ready, 3'b100);
        tick();
        check("b_h1_x", b_x, 6);
        #1;
        check("b_rdy_second", b_req_ready, 3'b001);
        tick();
        b_req_valid = 3'b000;
        check("b_h2_x", b_x, 1);
        check("b_r0_ov", b_ov, 1);
        check("b_r0_id", b_oid, 0);
        check("b_r0_od", b_od, 7);
        tick();
        check("b_r1_ov", b_ov, 1);
        check("b_r1_id", b_oid, 2);
        check("b_r1_od", b_od, 27);
        tick();
        check("b_r2_ov", b_ov, 1);
        check("b_r2_id", b_oid, 0);
        check("b_r2_od", b_od, 7);
        tick();
        check("b_end_ov", b_ov, 0);
        check("b_end_busy", b_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
